// File: rtl/pm_pkg.sv
// Shared constants and helpers for the parking meter: default button amounts,
// a ceil-log2 for sizing counters, and the active-low 7-segment table.
package pm_pkg;

    localparam logic [4*14-1:0] DEF_ADD_AMT    = {14'd300, 14'd180, 14'd120, 14'd60};
    localparam logic [2*14-1:0] DEF_PRESET_VAL = {14'd150, 14'd15};
    localparam logic [6:0]      SEG_BLANK      = 7'h7F;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Segment order {g,f,e,d,c,b,a}, low = lit; anything above 9 is blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin_to_bcd.sv
// Combinational double-dabble: binary seconds to DIGITS packed BCD digits.
module bin_to_bcd #(
    parameter int TIME_W = 14,
    parameter int DIGITS = 4
) (
    input  logic [TIME_W-1:0]   bin,
    output logic [4*DIGITS-1:0] bcd
);

    logic [4*DIGITS+TIME_W-1:0] sh;

    always_comb begin
        sh = '0;
        sh[TIME_W-1:0] = bin;
        for (int i = 0; i < TIME_W; i++) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (sh[TIME_W+4*d +: 4] >= 4'd5)
                    sh[TIME_W+4*d +: 4] = sh[TIME_W+4*d +: 4] + 4'd3;
            end
            sh = sh << 1;
        end
        bcd = sh[TIME_W +: 4*DIGITS];
    end

endmodule

// File: rtl/parking_meter_gen.sv
// Parking meter: coin/preset buttons load a seconds counter that counts down
// once per second, shown on a multiplexed active-low 7-segment display.
module parking_meter_gen
    import pm_pkg::*;
#(
    parameter int                        CLK_HZ     = 100,
    parameter int                        DIGITS     = 4,
    parameter int                        TIME_W     = 14,
    parameter int                        MAX_TIME   = 9999,
    parameter int                        N_ADD      = 4,
    parameter logic [N_ADD*TIME_W-1:0]   ADD_AMT    = DEF_ADD_AMT,
    parameter int                        N_PRESET   = 2,
    parameter logic [N_PRESET*TIME_W-1:0] PRESET_VAL = DEF_PRESET_VAL,
    parameter int                        LOW_THRESH = 180,
    parameter int                        SCAN_DIV   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_ADD-1:0]      add,
    input  logic [N_PRESET-1:0]   preset,
    input  logic                  pause,
    output logic [TIME_W-1:0]     time_left,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  expired,
    output logic                  low,
    output logic                  disp_on,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg
);

    localparam int TICK_W = (clog2(CLK_HZ) < 1) ? 1 : clog2(CLK_HZ);
    localparam int SCAN_W = (clog2(SCAN_DIV) < 1) ? 1 : clog2(SCAN_DIV);
    localparam int IDX_W  = (clog2(DIGITS) < 1) ? 1 : clog2(DIGITS);
    localparam int SUM_W  = TIME_W + clog2(N_ADD) + 1;

    logic [TICK_W-1:0]   tick_cnt;
    logic                sec_par;
    logic                sec_tick;
    logic [N_ADD-1:0]    add_q, add_rise;
    logic [N_PRESET-1:0] preset_q, preset_rise;
    logic [SUM_W-1:0]    sum;
    logic [TIME_W-1:0]   upd_time, preset_load;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [IDX_W-1:0]    scan_idx;
    logic                half;

    assign sec_tick    = (tick_cnt == TICK_W'(CLK_HZ - 1));
    assign add_rise    = add & ~add_q;
    assign preset_rise = preset & ~preset_q;

    // Sum is wide enough that every add firing at once cannot wrap before clamping.
    always_comb begin
        sum = SUM_W'(time_left);
        for (int i = 0; i < N_ADD; i++)
            if (add_rise[i]) sum = sum + SUM_W'(ADD_AMT[i*TIME_W +: TIME_W]);
        if (sum > SUM_W'(MAX_TIME)) sum = SUM_W'(MAX_TIME);
        upd_time = sum[TIME_W-1:0];
        if (sec_tick && !pause && upd_time != '0) upd_time = upd_time - 1'b1;
    end

    // Descending scan so the lowest-index rising preset wins.
    always_comb begin
        preset_load = '0;
        for (int j = N_PRESET - 1; j >= 0; j--)
            if (preset_rise[j]) preset_load = PRESET_VAL[j*TIME_W +: TIME_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            time_left <= '0;
            tick_cnt  <= '0;
            sec_par   <= 1'b0;
        end else if (|preset_rise) begin
            time_left <= preset_load;
            tick_cnt  <= '0;
            sec_par   <= 1'b0;
        end else begin
            time_left <= upd_time;
            tick_cnt  <= sec_tick ? '0 : tick_cnt + 1'b1;
            sec_par   <= sec_par ^ sec_tick;
        end
    end

    // Edge registers track levels even in reset so a held button never fires.
    always_ff @(posedge clk) begin
        add_q    <= add;
        preset_q <= preset;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    bin_to_bcd #(.TIME_W(TIME_W), .DIGITS(DIGITS)) u_bcd (
        .bin (time_left),
        .bcd (bcd)
    );

    assign expired = (time_left == '0);
    assign low     = !expired && (time_left < TIME_W'(LOW_THRESH));
    assign half    = (tick_cnt < TICK_W'(CLK_HZ / 2));

    always_comb begin
        disp_on = 1'b1;
        if (expired)  disp_on = half;
        else if (low) disp_on = ~sec_par;
    end

    assign an  = ~(DIGITS'(1) << scan_idx);
    assign seg = disp_on ? seg7(bcd[4*scan_idx +: 4]) : SEG_BLANK;

endmodule

// File: tb/tb_parking_meter_gen.sv
// Bench for parking_meter_gen: integer reference model checked every cycle,
// a vector table of held-input phases, hand sequences and random stimulus.
module tb_parking_meter_gen;

    localparam int CLK_HZ = 100;
    localparam int MAXT   = 9999;
    localparam int LOWT   = 180;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  add;
    logic [1:0]  preset;
    logic        pause;
    logic [13:0] time_left;
    logic [15:0] bcd;
    logic        expired, low, disp_on;
    logic [3:0]  an;
    logic [6:0]  seg;

    parking_meter_gen dut (
        .clk(clk), .rst(rst), .add(add), .preset(preset), .pause(pause),
        .time_left(time_left), .bcd(bcd), .expired(expired), .low(low),
        .disp_on(disp_on), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    int add_amt [4] = '{60, 120, 180, 300};
    int pre_val [2] = '{15, 150};
    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    int nerr = 0;
    int nchk = 0;

    // Reference model state
    int m_time, m_tick, m_par, m_sidx;
    logic [3:0] m_aq;
    logic [1:0] m_pq;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int digit(input int t, input int d);
        int v = t;
        for (int k = 0; k < d; k++) v = v / 10;
        return v % 10;
    endfunction

    task automatic model_step();
        int s;
        int j;
        logic sec;
        logic [3:0] ar;
        logic [1:0] pr;
        if (rst) begin
            m_time = 0; m_tick = 0; m_par = 0; m_sidx = 0;
        end else begin
            sec = (m_tick == CLK_HZ - 1);
            ar  = add & ~m_aq;
            pr  = preset & ~m_pq;
            if (pr != 0) begin
                j = pr[0] ? 0 : 1;
                m_time = pre_val[j];
                m_tick = 0;
                m_par  = 0;
            end else begin
                s = m_time;
                for (int i = 0; i < 4; i++) if (ar[i]) s += add_amt[i];
                if (s > MAXT) s = MAXT;
                if (sec && !pause && s > 0) s--;
                m_time = s;
                m_tick = sec ? 0 : m_tick + 1;
                if (sec) m_par = 1 - m_par;
            end
            m_sidx = (m_sidx + 1) % 4;
        end
        m_aq = add;
        m_pq = preset;
    endtask

    task automatic check_all();
        int eb, ee, el, ed, es;
        eb = 0;
        for (int d = 0; d < 4; d++) eb += digit(m_time, d) << (4 * d);
        ee = (m_time == 0);
        el = (m_time > 0 && m_time < LOWT);
        ed = ee ? (m_tick < CLK_HZ / 2) : (el ? (m_par == 0) : 1);
        es = ed ? seg_tab[digit(m_time, m_sidx)] : 7'h7F;
        chk("time_left", time_left, m_time);
        chk("bcd", bcd, eb);
        chk("expired", expired, ee);
        chk("low", low, el);
        chk("disp_on", disp_on, ed);
        chk("an", an, (~(1 << m_sidx)) & 4'hF);
        chk("seg", seg, es);
    endtask

    task automatic run(input logic r, input logic [3:0] a, input logic [1:0] p,
                       input logic pz, input int n);
        rst = r; add = a; preset = p; pause = pz;
        for (int k = 0; k < n; k++) begin
            model_step();
            @(posedge clk);
            #1;
            check_all();
        end
    endtask

    typedef struct {
        logic       r;
        logic [3:0] a;
        logic [1:0] p;
        logic       pz;
        int         n;
        int         exp_t;
    } vec_t;

    vec_t vt [13];

    initial begin
        rst = 1'b1; add = '0; preset = '0; pause = 1'b0;
        m_aq = '0; m_pq = '0;
        m_time = 0; m_tick = 0; m_par = 0; m_sidx = 0;

        vt[0]  = '{1'b1, 4'b0000, 2'b00, 1'b0,   2,   0};
        vt[1]  = '{1'b0, 4'b0000, 2'b00, 1'b0, 300,   0};
        vt[2]  = '{1'b0, 4'b0001, 2'b00, 1'b0,   1,  60};
        vt[3]  = '{1'b0, 4'b0000, 2'b00, 1'b0,   1,  60};
        vt[4]  = '{1'b0, 4'b0000, 2'b00, 1'b0,  97,  60};
        vt[5]  = '{1'b0, 4'b0000, 2'b00, 1'b0,   1,  59};
        vt[6]  = '{1'b0, 4'b1000, 2'b00, 1'b0, 500, 354};
        vt[7]  = '{1'b0, 4'b0000, 2'b10, 1'b0,   1, 150};
        vt[8]  = '{1'b0, 4'b0000, 2'b01, 1'b0,   1,  15};
        vt[9]  = '{1'b0, 4'b0000, 2'b00, 1'b0,   1,  15};
        vt[10] = '{1'b0, 4'b0100, 2'b11, 1'b0,   1,  15};
        vt[11] = '{1'b0, 4'b0000, 2'b00, 1'b1, 500,  15};
        vt[12] = '{1'b0, 4'b0000, 2'b00, 1'b0, 100,  14};

        for (int v = 0; v < 13; v++) begin
            run(vt[v].r, vt[v].a, vt[v].p, vt[v].pz, vt[v].n);
            chk($sformatf("vec%0d_time", v), time_left, vt[v].exp_t);
        end

        // Saturation from zero
        run(1, 0, 0, 0, 1);
        for (int k = 0; k < 34; k++) begin
            run(0, 4'b1000, 0, 0, 1);
            run(0, 4'b0000, 0, 0, 1);
        end
        chk("sat_time", time_left, 9999);
        chk("sat_bcd", bcd, 16'h9999);

        // Two adds rising together
        run(1, 0, 0, 0, 1);
        run(0, 4'b0011, 0, 0, 1);
        chk("dual_add_time", time_left, 180);
        chk("dual_add_low", low, 0);

        // Reset beats an add edge and a second tick in the same cycle
        run(1, 0, 0, 0, 1);
        run(0, 0, 2'b10, 0, 1);
        run(0, 4'b0001, 0, 0, 1);
        run(0, 0, 0, 0, 98);
        chk("pre_rst_time", time_left, 210);
        run(1, 4'b1000, 0, 0, 1);
        chk("rst_prio_time", time_left, 0);
        run(1, 4'b0010, 0, 0, 1);
        run(0, 4'b0010, 0, 0, 5);
        chk("held_thru_rst", time_left, 0);

        // Full countdown to expiry
        run(1, 0, 0, 0, 1);
        run(0, 4'b0001, 0, 0, 1);
        chk("one_add_bcd", bcd, 16'h0060);
        chk("one_add_low", low, 1);
        run(0, 0, 0, 0, 6100);
        chk("expiry_time", time_left, 0);
        chk("expiry_flag", expired, 1);

        // Random stimulus
        for (int k = 0; k < 4000; k++) begin
            logic       r;
            logic [3:0] a;
            logic [1:0] p;
            logic       pz;
            r  = ($urandom_range(0, 199) == 0);
            a  = add ^ (($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'h0);
            p  = preset ^ (($urandom_range(0, 59) == 0) ? 2'($urandom_range(0, 3)) : 2'h0);
            pz = ($urandom_range(0, 49) == 0) ? ~pause : pause;
            run(r, a, p, pz, 1);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
